// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// ram_access_arbiter: shares one registered-read RAM between IF and LS ports.
// Optional ARB_ROUND_ROBIN_EN alternates contested grants.  Rev 1.0
// ============================================================================
module ram_access_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [2:0] C_LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              win_ls_q, win_ls_d;
  logic              is_wr_q, is_wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic w_cand_if, w_cand_ls, w_pick_ls, w_prio_ls;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_ls_q, ptr_ls_d;

  always_comb begin
    ptr_ls_d = ptr_ls_q;
    if (state_q == ISSUE) ptr_ls_d = ~win_ls_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_ls_q <= 1'b0;
    else        ptr_ls_q <= ptr_ls_d;
  end

  assign w_prio_ls = ptr_ls_q;
`else
  assign w_prio_ls = 1'b1;
`endif

  // The port being granted in ISSUE still holds its request; mask it so a
  // write cannot be issued twice.
  always_comb begin
    w_cand_if = if_req & ~((state_q == ISSUE) & ~win_ls_q);
    w_cand_ls = ls_req & ~((state_q == ISSUE) &  win_ls_q);
    w_pick_ls = w_cand_ls & (~w_cand_if | w_prio_ls);
  end

  always_comb begin
    state_d     = state_q;
    win_ls_d    = win_ls_q;
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) state_d = IDLE;
        if (w_cand_if | w_cand_ls) state_d = ISSUE;
      end
      ISSUE: begin
        if (is_wr_q) begin
          state_d = IDLE;
          if (w_cand_if | w_cand_ls) state_d = ISSUE;
        end else begin
          state_d = WAIT;
          cnt_d   = C_LAT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          if (win_ls_q) ls_rdata_d = ram_rdata;
          else          if_rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading the winner on every transition into ISSUE keeps the RAM lines
    // registered without a separate issue path.
    if (state_d == ISSUE) begin
      win_ls_d   = w_pick_ls;
      is_wr_d    = w_pick_ls & ls_we;
      ram_addr_d = w_pick_ls ? ls_addr : if_addr;
      if (w_pick_ls & ls_we) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = ls_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_ls_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      cnt_q       <= 3'd0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      win_ls_q    <= win_ls_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign if_gnt    = (state_q == ISSUE) & ~win_ls_q;
  assign ls_gnt    = (state_q == ISSUE) &  win_ls_q;
  assign if_rvalid = (state_q == RESP)  & ~win_ls_q;
  assign ls_rvalid = (state_q == RESP)  &  win_ls_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// Directed bench: latency-1 arbiter plus a latency-3 instance for the WAIT path.
module tb_ram_access_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A, RD_LATENCY = 1 ----------------
  logic        if_req = 0, ls_req = 0, ls_we = 0;
  logic [15:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_we, busy;
  logic [15:0] if_rdata, ls_rdata, ram_addr, ram_wdata, ram_rdata;

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  logic [15:0] mem_a [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_wdata;
    ram_rdata <= mem_a[ram_addr];
  end

  // ---------------- instance B, RD_LATENCY = 3 ----------------
  logic        b_if_req = 0, b_ls_req = 0, b_ls_we = 0;
  logic [15:0] b_if_addr = 0, b_ls_addr = 0, b_ls_wdata = 0;
  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_ram_we, b_busy;
  logic [15:0] b_if_rdata, b_ls_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [15:0] b_p0, b_p1;

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  logic [15:0] mem_b [0:65535];
  always @(posedge clk) begin
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
    b_p0        <= mem_b[b_ram_addr];
    b_p1        <= b_p0;
    b_ram_rdata <= b_p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    mem_a[16'h85A1] = 16'd1000;
    mem_a[16'h8449] = 16'd5000;
    mem_b[16'h85A1] = 16'd1000;

    // Reset state
    nc(); nc();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {if_gnt, ls_gnt}, 0);
    chk("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    chk("rst_ram", {ram_addr, ram_we, ram_wdata}, 0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 0);
    rst_n = 1'b1;
    nc();

    // IF read of 0x85A1: gnt C+1, rvalid C+3
    if_req = 1; if_addr = 16'h85A1;
    nc();
    chk("t1_if_gnt", {if_gnt, ls_gnt}, 2'b10);
    chk("t1_ram_addr", ram_addr, 16'h85A1);
    chk("t1_busy1", busy, 1);
    chk("t1_we", ram_we, 0);
    if_req = 0;
    nc();
    chk("t1_no_rvalid_c2", if_rvalid, 0);
    chk("t1_busy2", busy, 1);
    nc();
    chk("t1_if_rvalid", {if_rvalid, ls_rvalid}, 2'b10);
    chk("t1_if_rdata", if_rdata, 16'd1000);
    chk("t1_busy3", busy, 1);
    nc();
    chk("t1_idle", {busy, if_rvalid}, 0);

`ifndef ARB_ROUND_ROBIN_EN
    // Simultaneous requests: LS first, IF back-to-back from RESP
    if_req = 1; if_addr = 16'h85A1;
    ls_req = 1; ls_we = 0; ls_addr = 16'h8449;
    nc();
    chk("t2_ls_gnt", {if_gnt, ls_gnt}, 2'b01);
    chk("t2_ram_addr_ls", ram_addr, 16'h8449);
    ls_req = 0;
    nc();
    chk("t2_wait_gnt", {if_gnt, ls_gnt}, 0);
    nc();
    chk("t2_ls_rvalid", {if_rvalid, ls_rvalid}, 2'b01);
    chk("t2_ls_rdata", ls_rdata, 16'd5000);
    nc();
    chk("t2_if_gnt_b2b", {if_gnt, ls_gnt}, 2'b10);
    chk("t2_busy_b2b", busy, 1);
    chk("t2_ram_addr_if", ram_addr, 16'h85A1);
    if_req = 0;
    nc(); nc();
    chk("t2_if_rvalid", {if_rvalid, ls_rvalid}, 2'b10);
    chk("t2_if_rdata", if_rdata, 16'd1000);
    chk("t2_ls_rdata_kept", ls_rdata, 16'd5000);
    nc();
    chk("t2_idle", busy, 0);
`else
    // Both requests held: grants alternate IF, LS, IF, LS from reset
    rst_n = 0; nc(); rst_n = 1; nc();
    if_req = 1; if_addr = 16'h85A1;
    ls_req = 1; ls_we = 0; ls_addr = 16'h8449;
    begin
      logic [3:0] order;
      int ng;
      ng = 0; order = 4'b0000;
      for (int c = 0; c < 40 && ng < 4; c++) begin
        nc();
        chk("rr_one_gnt", {1'b0, if_gnt & ls_gnt}, 0);
        if (if_gnt | ls_gnt) begin
          order[ng] = ls_gnt;
          ng++;
        end
      end
      chk("rr_count", ng, 4);
      chk("rr_order", order, 4'b1010);
    end
    if_req = 0; ls_req = 0;
    nc(); nc(); nc(); nc();
`endif

    // LS write 0x0010 <= 0xBEEF: one-cycle ram_we, no rvalid
    ls_req = 1; ls_we = 1; ls_addr = 16'h0010; ls_wdata = 16'hBEEF;
    nc();
    chk("t3_ls_gnt", {if_gnt, ls_gnt}, 2'b01);
    chk("t3_ram_we", ram_we, 1);
    chk("t3_ram_wr", {ram_addr, ram_wdata}, {16'h0010, 16'hBEEF});
    ls_req = 0; ls_we = 0;
    nc();
    chk("t3_we_off", ram_we, 0);
    chk("t3_no_rvalid", {if_rvalid, ls_rvalid}, 0);
    chk("t3_idle", busy, 0);
    nc();
    chk("t3_no_rvalid2", ls_rvalid, 0);
    if_req = 1; if_addr = 16'h0010;
    nc();
    chk("t3_rd_gnt", if_gnt, 1);
    if_req = 0;
    nc(); nc();
    chk("t3_rd_rvalid", if_rvalid, 1);
    chk("t3_rd_data", if_rdata, 16'hBEEF);
    nc();

    // Reset during WAIT aborts the LS read
    ls_req = 1; ls_we = 0; ls_addr = 16'h8449;
    nc();
    chk("t4_gnt", ls_gnt, 1);
    ls_req = 0;
    nc();
    rst_n = 0;
    #1;
    chk("t4_busy0", busy, 0);
    chk("t4_outs0", {ram_addr, ram_we, ram_wdata, if_gnt, ls_gnt}, 0);
    chk("t4_rdata0", {if_rdata, ls_rdata}, 0);
    nc();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      nc();
      chk("t4_no_rvalid", {ls_rvalid, if_rvalid, busy}, 0);
    end

    // Latency-3 instance: rvalid at C+5, ram_addr held through WAIT
    b_if_req = 1; b_if_addr = 16'h85A1;
    nc();
    chk("t5_gnt", b_if_gnt, 1);
    chk("t5_addr", b_ram_addr, 16'h85A1);
    b_if_req = 0;
    for (int c = 2; c <= 4; c++) begin
      nc();
      chk("t5_wait_rvalid", b_if_rvalid, 0);
      chk("t5_wait_addr", {b_ram_addr, b_ram_we, b_busy}, {16'h85A1, 1'b0, 1'b1});
    end
    nc();
    chk("t5_rvalid", b_if_rvalid, 1);
    chk("t5_rdata", b_if_rdata, 16'd1000);
    nc();
    chk("t5_idle", {b_busy, b_if_rvalid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port 16-bit RAM between two requesters: instruction fetch (IF) and load/store (LS).
- Sequences each access against the RAM's registered read path, then returns the read data to the winning requester with a one-cycle valid pulse.
- Sits between the CPU controller/datapath and the RAM instance.
- The block owns the RAM address, write-enable and write-data lines.

Parameters:
- ADDR_W, 16, address width of requesters and RAM.
- DATA_W, 16, data width.
- RD_LATENCY, 1, number of clock edges from the RAM sampling an address to valid read data. Legal range 1..4; a 3-bit counter is sufficient.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch issued to RAM.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data, registered.
- ls_req  in  1  load/store request, held until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  one-cycle pulse: LS access issued.
- ls_rvalid  out  1  one-cycle pulse, reads only.
- ls_rdata  out  DATA_W  load read data, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM registered read output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs are 0, including rdata registers and ram_addr. The wait counter is 0 and the round-robin pointer points to IF.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - If any request is pending, arbitrate and go to ISSUE at the next edge.
  - Load ram_addr, and ram_wdata/ram_we for an LS write, from the winner.
  - Latch the winner ID and the read/write flag.
- ISSUE (1 cycle):
  - Winner's gnt = 1.
  - ram_we = 1 only for an LS write.
  - Write: go to IDLE, or back to ISSUE if a request is pending, with no rvalid.
  - Read: go to WAIT, with the counter loaded to RD_LATENCY.
- WAIT:
  - Lasts RD_LATENCY cycles, with the counter decrementing each cycle.
  - ram_addr is held stable and ram_we = 0.
  - When the counter reaches 1, capture ram_rdata into the winner's rdata register and go to RESP.
- RESP (1 cycle):
  - Winner's rvalid = 1.
  - The other requester's rdata register is unchanged.
  - Arbitrate again: on a pending request go to ISSUE (back-to-back), otherwise go to IDLE.
- Timing: a request first seen in cycle C (IDLE) gives gnt in C+1. For a read, rvalid comes in C+2+RD_LATENCY; with the default that is C+3. A write occupies the RAM in cycle C+1 only.
- Arbitration is fixed priority: LS wins over IF when both requests are present in the same cycle.
- Requests are sampled only in IDLE and RESP (and ISSUE for a write). Request changes during WAIT are ignored because the access is committed.
- Requesters must hold addr, we and wdata stable until their gnt. A request deasserted before its gnt is simply not served.
- gnt and rvalid are never asserted for both ports in the same cycle.
- A reset during WAIT or RESP aborts the access; no rvalid is produced after reset release.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests are granted alternately.
  - The pointer flips to the other port after every issued access.
  - A single requester is served regardless of the pointer.
  - The first contested grant after reset goes to IF.
- Not defined: fixed LS-over-IF priority; no pointer register exists.

Test Plan:
- RAM model preloaded with 0x85A1 = 1000 and 0x8449 = 5000. if_req with if_addr = 0x85A1 in cycle 0 -> if_gnt in cycle 1, ram_addr = 0x85A1, if_rvalid in cycle 3 with if_rdata = 1000, busy high in cycles 1-3.
- if_req at 0x85A1 and ls_req read at 0x8449 in the same cycle, fixed priority -> ls_gnt first, ls_rdata = 5000; then back-to-back if_gnt from RESP, if_rdata = 1000; no idle cycle between the two accesses.
- ls_req write, ls_addr = 0x0010, ls_wdata = 0xBEEF -> ram_we high for exactly one cycle alongside ls_gnt, no ls_rvalid. A subsequent read of 0x0010 returns 0xBEEF.
- RD_LATENCY = 3, IF read -> if_rvalid in cycle 5 after the request; ram_addr held stable for the 3 WAIT cycles.
- Read in flight, rst_n pulsed low during WAIT -> all outputs 0 immediately, no rvalid afterwards, state IDLE.
- With ARB_ROUND_ROBIN_EN, both requests held continuously for 4 accesses -> grant order IF, LS, IF, LS.
